// File: rtl/bfs_visit_filter.sv
// Visited-bitmap filter placed in front of the BFS main queue.
// It accepts pairs of neighbour IDs and drops any ID that has already been visited,
// that falls outside the node range, or that repeats the other ID in the same pair.
// Each surviving ID is marked in the bitmap and presented on the queue's dual-enqueue port.
// The block also walks the bitmap once to clear it after reset or when a clear is requested.
module bfs_visit_filter #(
    parameter int NODE_BITS = 10,
    parameter int WORD_BITS = 32
) (
    input  logic                 clk,
    input  logic                 bfs_rst_n,
    input  logic                 clear_start,
    output logic                 clear_busy,
    input  logic [1:0]           in_valid,
    input  logic [63:0]          in_data,
    output logic                 in_ready,
    output logic [1:0]           enqueue_req,
    output logic [63:0]          wdata_out,
    input  logic                 queue_full,
    output logic [NODE_BITS:0]   discovered_cnt,
    output logic                 filter_idle,
    output logic                 err_oob
);

    localparam int NUM_WORDS = (2 ** NODE_BITS) / WORD_BITS;
    localparam int WIDX_W    = $clog2(NUM_WORDS);
    localparam int BIT_W     = $clog2(WORD_BITS);
    localparam logic [WIDX_W-1:0]    LAST_IDX  = WIDX_W'(NUM_WORDS - 1);
    localparam logic [NODE_BITS+1:0] CNT_MAX_W = (NODE_BITS + 2)'(2 ** NODE_BITS);
    localparam logic [NODE_BITS:0]   CNT_MAX   = (NODE_BITS + 1)'(2 ** NODE_BITS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDX_W-1:0]      clear_idx_q, clear_idx_d;
    logic [1:0]             enqueue_req_q, enqueue_req_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [NODE_BITS:0]     cnt_q, cnt_d;
    logic                   err_oob_q, err_oob_d;

    // The bitmap is not reset. The CLEAR walk is what initialises it.
    logic [WORD_BITS-1:0]   bitmap_q [NUM_WORDS];
    logic [WORD_BITS-1:0]   bitmap_d [NUM_WORDS];

    // Per-slot decode. Slot 1 is the high word of in_data.
    logic [1:0][31:0]       slot_id;
    logic [1:0]             slot_in_range;
    logic [1:0]             slot_seen;
    logic [WIDX_W-1:0]      slot_widx [2];
    logic [BIT_W-1:0]       slot_bidx [2];

    logic                   accept;
    logic [1:0]             survivors;
    logic                   oob_hit;
    logic [1:0]             pop;
    logic [NODE_BITS+1:0]   cnt_sum;

    assign slot_id = in_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_in_range[gi] = (slot_id[gi][31:NODE_BITS] == '0);
            assign slot_widx[gi]     = slot_id[gi][NODE_BITS-1:BIT_W];
            assign slot_bidx[gi]     = slot_id[gi][BIT_W-1:0];
            // The bitmap is read combinationally, so a pair is filtered in the same cycle it is accepted.
            assign slot_seen[gi]     = bitmap_q[slot_widx[gi]][slot_bidx[gi]];
        end
    endgenerate

    assign clear_busy     = (state_q == ST_CLEAR);
    assign in_ready       = (state_q == ST_RUN) && ((enqueue_req_q == 2'b00) || !queue_full);
    assign filter_idle    = (state_q == ST_RUN) && (enqueue_req_q == 2'b00);
    assign enqueue_req    = enqueue_req_q;
    assign wdata_out      = wdata_q;
    assign discovered_cnt = cnt_q;
    assign err_oob        = err_oob_q;
    assign accept         = in_ready && (in_valid != 2'b00);

    // Survivor selection: if both IDs in a pair are equal, only the high slot is kept.
    always_comb begin
        survivors = in_valid & slot_in_range & ~slot_seen;
        if ((survivors == 2'b11) && (slot_id[1] == slot_id[0])) begin
            survivors[0] = 1'b0;
        end
        if (!accept) begin
            survivors = 2'b00;
        end
        oob_hit = accept && ((in_valid & ~slot_in_range) != 2'b00);
        pop     = {1'b0, survivors[1]} + {1'b0, survivors[0]};
        cnt_sum = {1'b0, cnt_q} + (NODE_BITS + 2)'(pop);
    end

    // Next-state logic for the FSM, the output register, the counter and the error flag.
    always_comb begin
        state_d       = state_q;
        clear_idx_d   = clear_idx_q;
        enqueue_req_d = enqueue_req_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        err_oob_d     = err_oob_q;

        case (state_q)
            ST_CLEAR: begin
                if (clear_idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    clear_idx_d = '0;
                end else begin
                    clear_idx_d = clear_idx_q + WIDX_W'(1);
                end
            end
            default: begin
            end
        endcase

        if (accept) begin
            enqueue_req_d = survivors;
            wdata_d       = in_data;
            cnt_d         = (cnt_sum >= CNT_MAX_W) ? CNT_MAX : cnt_sum[NODE_BITS:0];
        end else if (!queue_full) begin
            enqueue_req_d = 2'b00;
        end

        if (oob_hit) begin
            err_oob_d = 1'b1;
        end

        // A clear request restarts the walk and discards any pending output.
        if (clear_start) begin
            state_d       = ST_CLEAR;
            clear_idx_d   = '0;
            enqueue_req_d = 2'b00;
            cnt_d         = '0;
        end
    end

    // Bitmap next value: zero the word being cleared, and set the bits of the survivors.
    always_comb begin
        bitmap_d = bitmap_q;
        if (state_q == ST_CLEAR) begin
            bitmap_d[clear_idx_q] = '0;
        end
        for (int s = 0; s < 2; s++) begin
            if (survivors[s]) begin
                bitmap_d[slot_widx[s]][slot_bidx[s]] = 1'b1;
            end
        end
    end

    // Bitmap storage. It has no reset.
    always_ff @(posedge clk) begin
        bitmap_q <= bitmap_d;
    end

    // Control and output registers, with asynchronous active-low reset.
    always_ff @(posedge clk or negedge bfs_rst_n) begin
        if (!bfs_rst_n) begin
            state_q       <= ST_CLEAR;
            clear_idx_q   <= '0;
            enqueue_req_q <= 2'b00;
            wdata_q       <= '0;
            cnt_q         <= '0;
            err_oob_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clear_idx_q   <= clear_idx_d;
            enqueue_req_q <= enqueue_req_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            err_oob_q     <= err_oob_d;
        end
    end

endmodule

// File: tb/tb_bfs_visit_filter.sv
// Directed testbench for bfs_visit_filter (NODE_BITS=10, WORD_BITS=32).
module tb_bfs_visit_filter;

    logic        clk;
    logic        bfs_rst_n;
    logic        clear_start;
    logic        clear_busy;
    logic [1:0]  in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic [1:0]  enqueue_req;
    logic [63:0] wdata_out;
    logic        queue_full;
    logic [10:0] discovered_cnt;
    logic        filter_idle;
    logic        err_oob;

    int passed = 0;
    int total  = 0;

    bfs_visit_filter #(.NODE_BITS(10), .WORD_BITS(32)) dut (
        .clk            (clk),
        .bfs_rst_n      (bfs_rst_n),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .enqueue_req    (enqueue_req),
        .wdata_out      (wdata_out),
        .queue_full     (queue_full),
        .discovered_cnt (discovered_cnt),
        .filter_idle    (filter_idle),
        .err_oob        (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count the cycles until clear_busy falls, with a bound on the wait.
    task automatic count_clear(input string name);
        int n;
        n = 0;
        while (clear_busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n !== 32) $display("FAIL %s_clear_cycles: got %0d exp 32", name, n); else passed++;
    endtask

    task automatic test_reset();
        bfs_rst_n = 1'b0; clear_start = 1'b0; in_valid = 2'b00; in_data = '0; queue_full = 1'b0;
        repeat (3) tick();
        total++; if (clear_busy !== 1'b1) $display("FAIL rst_busy: got %b exp 1", clear_busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", in_ready); else passed++;
        total++; if (filter_idle !== 1'b0) $display("FAIL rst_idle: got %b exp 0", filter_idle); else passed++;
        total++; if (enqueue_req !== 2'b00) $display("FAIL rst_enq: got %b exp 00", enqueue_req); else passed++;
        total++; if (wdata_out !== 64'd0) $display("FAIL rst_wdata: got %h exp 0", wdata_out); else passed++;
        total++; if (err_oob !== 1'b0) $display("FAIL rst_oob: got %b exp 0", err_oob); else passed++;
        bfs_rst_n = 1'b1;
        count_clear("rst");
        total++; if (in_ready !== 1'b1) $display("FAIL rst_ready_after: got %b exp 1", in_ready); else passed++;
        total++; if (filter_idle !== 1'b1) $display("FAIL rst_idle_after: got %b exp 1", filter_idle); else passed++;
        total++; if (discovered_cnt !== 11'd0) $display("FAIL rst_cnt: got %0d exp 0", discovered_cnt); else passed++;
        $display("[tb] reset: clear walk complete");
    endtask

    task automatic test_basic();
        in_valid = 2'b11; in_data = {32'd5, 32'd7};
        tick();
        total++; if (enqueue_req !== 2'b11) $display("FAIL basic_enq1: got %b exp 11", enqueue_req); else passed++;
        total++; if (wdata_out !== {32'd5, 32'd7}) $display("FAIL basic_wdata1: got %h exp %h", wdata_out, {32'd5, 32'd7}); else passed++;
        total++; if (discovered_cnt !== 11'd2) $display("FAIL basic_cnt1: got %0d exp 2", discovered_cnt); else passed++;
        $display("[tb] pair {5,7} -> enq %b", enqueue_req);
        in_data = {32'd7, 32'd9};
        tick();
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b01) $display("FAIL basic_enq2: got %b exp 01", enqueue_req); else passed++;
        total++; if (wdata_out[31:0] !== 32'd9) $display("FAIL basic_wdata2: got %0d exp 9", wdata_out[31:0]); else passed++;
        total++; if (discovered_cnt !== 11'd3) $display("FAIL basic_cnt2: got %0d exp 3", discovered_cnt); else passed++;
        $display("[tb] pair {7,9} -> enq %b", enqueue_req);
        tick();
        total++; if (enqueue_req !== 2'b00) $display("FAIL basic_enq_drain: got %b exp 00", enqueue_req); else passed++;
        total++; if (filter_idle !== 1'b1) $display("FAIL basic_idle: got %b exp 1", filter_idle); else passed++;
    endtask

    task automatic test_duplicate();
        in_valid = 2'b11; in_data = {32'd12, 32'd12};
        tick();
        total++; if (enqueue_req !== 2'b10) $display("FAIL dup_enq1: got %b exp 10", enqueue_req); else passed++;
        $display("[tb] pair {12,12} -> enq %b", enqueue_req);
        in_valid = 2'b10; in_data = {32'd12, 32'd99};
        tick();
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b00) $display("FAIL dup_enq2: got %b exp 00", enqueue_req); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL dup_ready: got %b exp 1", in_ready); else passed++;
        total++; if (discovered_cnt !== 11'd4) $display("FAIL dup_cnt: got %0d exp 4", discovered_cnt); else passed++;
        $display("[tb] pair {12,x} -> enq %b", enqueue_req);
    endtask

    task automatic test_backpressure();
        in_valid = 2'b11; in_data = {32'd20, 32'd21};
        tick();
        queue_full = 1'b1; in_data = {32'd22, 32'd23};
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b exp 0", in_ready); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (enqueue_req !== 2'b11 || wdata_out !== {32'd20, 32'd21})
                $display("FAIL bp_hold%0d: got %b/%h exp 11/%h", i, enqueue_req, wdata_out, {32'd20, 32'd21}); else passed++;
        end
        queue_full = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_release: got %b exp 1", in_ready); else passed++;
        tick();
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b11 || wdata_out !== {32'd22, 32'd23})
            $display("FAIL bp_next: got %b/%h exp 11/%h", enqueue_req, wdata_out, {32'd22, 32'd23}); else passed++;
        total++; if (discovered_cnt !== 11'd8) $display("FAIL bp_cnt: got %0d exp 8", discovered_cnt); else passed++;
        $display("[tb] backpressure pair {22,23} -> enq %b", enqueue_req);
        tick();
    endtask

    task automatic test_oob();
        in_valid = 2'b11; in_data = {32'd30, 32'h400};
        tick();
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b10) $display("FAIL oob_enq: got %b exp 10", enqueue_req); else passed++;
        total++; if (err_oob !== 1'b1) $display("FAIL oob_flag: got %b exp 1", err_oob); else passed++;
        total++; if (discovered_cnt !== 11'd9) $display("FAIL oob_cnt: got %0d exp 9", discovered_cnt); else passed++;
        $display("[tb] pair {30,0x400} -> enq %b oob %b", enqueue_req, err_oob);
        repeat (3) tick();
        total++; if (err_oob !== 1'b1) $display("FAIL oob_sticky: got %b exp 1", err_oob); else passed++;
    endtask

    task automatic test_clear();
        in_valid = 2'b11; in_data = {32'd40, 32'd41};
        tick();
        in_valid = 2'b00; queue_full = 1'b1; clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        total++; if (enqueue_req !== 2'b00) $display("FAIL clr_enq_drop: got %b exp 00", enqueue_req); else passed++;
        total++; if (discovered_cnt !== 11'd0) $display("FAIL clr_cnt: got %0d exp 0", discovered_cnt); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL clr_ready: got %b exp 0", in_ready); else passed++;
        count_clear("clr");
        queue_full = 1'b0;
        total++; if (err_oob !== 1'b1) $display("FAIL clr_oob_kept: got %b exp 1", err_oob); else passed++;
        in_valid = 2'b11; in_data = {32'd5, 32'd7};
        tick();
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b11) $display("FAIL clr_resubmit: got %b exp 11", enqueue_req); else passed++;
        total++; if (discovered_cnt !== 11'd2) $display("FAIL clr_cnt2: got %0d exp 2", discovered_cnt); else passed++;
        $display("[tb] resubmit {5,7} after clear -> enq %b", enqueue_req);
        // Apply reset partway through a clear walk. The walk must start again from word 0.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (10) tick();
        bfs_rst_n = 1'b0;
        #1;
        total++; if (err_oob !== 1'b0) $display("FAIL rst2_oob: got %b exp 0", err_oob); else passed++;
        total++; if (clear_busy !== 1'b1) $display("FAIL rst2_busy: got %b exp 1", clear_busy); else passed++;
        tick();
        bfs_rst_n = 1'b1;
        count_clear("rst2");
    endtask

    task automatic test_back_to_back();
        // Submit every node once, back-to-back. The count must end at 1024.
        for (int k = 0; k < 512; k++) begin
            in_valid = 2'b11;
            in_data = {32'(2 * k + 1), 32'(2 * k)};
            tick();
        end
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b11) $display("FAIL b2b_last_enq: got %b exp 11", enqueue_req); else passed++;
        total++; if (discovered_cnt !== 11'd1024) $display("FAIL b2b_cnt: got %0d exp 1024", discovered_cnt); else passed++;
        $display("[tb] 512 pairs -> cnt %0d", discovered_cnt);
        in_valid = 2'b11; in_data = {32'd0, 32'd1};
        tick();
        in_valid = 2'b00;
        total++; if (enqueue_req !== 2'b00) $display("FAIL b2b_revisit: got %b exp 00", enqueue_req); else passed++;
        total++; if (discovered_cnt !== 11'd1024) $display("FAIL b2b_cnt_hold: got %0d exp 1024", discovered_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duplicate();
        test_backpressure();
        test_oob();
        test_clear();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
